// File: rtl/referee_pkg.sv
// Shared types and defaults for the round referee: FSM state encoding,
// default timing/score constants and the point-qualification rule.
package referee_pkg;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVER = 2'd2
  } state_e;

  localparam int DEFAULT_HOLD_CYCLES = 4;
  localparam int DEFAULT_MAX_SCORE   = 7;

  // A point needs exactly one lit end light and a lone press from that end's player.
  function automatic logic point_won(input logic edge_own, input logic edge_other,
                                     input logic press_own, input logic press_other);
    return edge_own & ~edge_other & press_own & ~press_other;
  endfunction

endpackage

// File: rtl/key_press.sv
// Rising-edge detector for a synchronized player key; one press per key-down.
module key_press (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = key;
  end

  // Resetting to 1 means a key held through reset release is not a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign press = key & ~prev_q;

endmodule

// File: rtl/round_referee.sv
// Referee for a two-player reaction game: awards points, pauses after each
// point, and latches the winner once a player reaches the target score.
module round_referee
  import referee_pkg::*;
#(
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int MAX_SCORE   = DEFAULT_MAX_SCORE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       edge_l,
  input  logic       edge_r,
  input  logic       key_l,
  input  logic       key_r,
  output logic       round_reset,
  output logic [2:0] score_l,
  output logic [2:0] score_r,
  output logic       game_over,
  output logic       winner
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [2:0] MAX_S     = 3'(MAX_SCORE);

  state_e     state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] score_l_q, score_l_d;
  logic [2:0] score_r_q, score_r_d;
  logic       round_reset_q, round_reset_d;
  logic       game_over_q, game_over_d;
  logic       winner_q, winner_d;

  logic       press_l, press_r;
  logic       point_l, point_r;
  logic [2:0] score_l_inc, score_r_inc;

  key_press u_key_l (
    .clk   (clk),
    .reset (reset),
    .key   (key_l),
    .press (press_l)
  );

  key_press u_key_r (
    .clk   (clk),
    .reset (reset),
    .key   (key_r),
    .press (press_r)
  );

  always_comb begin
    point_l     = point_won(edge_l, edge_r, press_l, press_r);
    point_r     = point_won(edge_r, edge_l, press_r, press_l);
    score_l_inc = score_l_q + 3'd1;
    score_r_inc = score_r_q + 3'd1;

    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    score_l_d     = score_l_q;
    score_r_d     = score_r_q;
    round_reset_d = 1'b0;
    game_over_d   = game_over_q;
    winner_d      = winner_q;

    unique case (state_q)
      ST_PLAY: begin
        if (point_l || point_r) begin
          round_reset_d = 1'b1;
          hold_cnt_d    = 4'd0;
          if (point_l) begin
            score_l_d = score_l_inc;
          end else begin
            score_r_d = score_r_inc;
          end
          // The winning point skips HOLD so the final score freezes immediately.
          if ((point_l && score_l_inc == MAX_S) || (point_r && score_r_inc == MAX_S)) begin
            state_d     = ST_OVER;
            game_over_d = 1'b1;
            winner_d    = point_r;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_PLAY;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      ST_OVER: begin
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_PLAY;
      hold_cnt_q    <= 4'd0;
      score_l_q     <= 3'd0;
      score_r_q     <= 3'd0;
      round_reset_q <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      round_reset_q <= round_reset_d;
      game_over_q   <= game_over_d;
      winner_q      <= winner_d;
    end
  end

  assign round_reset = round_reset_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;

endmodule
